// File: rtl/net_stats_agg.sv
// Purpose: per-event statistics counters with snapshot shadow, delayed stats bus and stream stall monitor.
// Latency: counters/shadow/rd_data update 1 cycle after sampling; stats_out and snap_done 1+STATS_DELAY cycles after snap.
// Backpressure: none; every input is accepted every cycle.
module net_stats_agg #(
    parameter int N_CNT       = 16,
    parameter int CNT_BITS    = 32,
    parameter int SATURATE    = 1,
    parameter int STATS_DELAY = 4,
    parameter int DOWN_THRS   = 256
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic [N_CNT-1:0]          evt_inc,
    input  logic                      snap,
    input  logic                      clr,
    input  logic [5:0]                rd_idx,
    output logic [CNT_BITS-1:0]       rd_data,
    output logic [N_CNT*CNT_BITS-1:0] stats_out,
    output logic                      snap_done,
    output logic [N_CNT-1:0]          ovf,
    input  logic                      mon_valid,
    input  logic                      mon_ready,
    output logic                      stream_down
);

    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [15:0]          THRS     = 16'(DOWN_THRS);
    localparam logic [STATS_DELAY:0] DONE_ONE = {{STATS_DELAY{1'b0}}, 1'b1};

    logic [CNT_BITS-1:0] cnt_q    [N_CNT];
    logic [CNT_BITS-1:0] cnt_d    [N_CNT];
    logic [CNT_BITS-1:0] shadow_q [N_CNT];
    logic [CNT_BITS-1:0] shadow_d [N_CNT];
    logic [N_CNT-1:0]    ovf_q;
    logic [N_CNT-1:0]    ovf_d;

    logic [N_CNT*CNT_BITS-1:0] shadow_flat;

    logic [STATS_DELAY:0] done_q;
    logic [STATS_DELAY:0] done_d;

    logic [CNT_BITS-1:0] rd_data_q;
    logic [CNT_BITS-1:0] rd_data_d;

    logic [15:0] stall_q;
    logic [15:0] stall_d;
    logic        stream_down_q;
    logic        stream_down_d;

    // Live counter and overflow next state; clear beats a coincident increment.
    always_comb begin
        for (int i = 0; i < N_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (evt_inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Shadow captures the pre-increment, pre-clear live values on snap.
    always_comb begin
        for (int i = 0; i < N_CNT; i++) begin
            shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
        end
    end

    // Counter, overflow and shadow registers.
    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CNT; g++) begin : g_flat
            assign shadow_flat[g*CNT_BITS +: CNT_BITS] = shadow_q[g];
        end
    endgenerate

    // done_q[0] marks the cycle the shadow changes; bit k follows k cycles later.
    always_comb begin
        done_d = (done_q << 1) | (snap ? DONE_ONE : '0);
    end

    // Snapshot completion shift register, flushed by reset so no stale pulse survives.
    always_ff @(posedge aclk) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    assign snap_done = done_q[STATS_DELAY];

    generate
        if (STATS_DELAY == 0) begin : g_nodelay
            assign stats_out = shadow_flat;
        end else begin : g_delay
            logic [N_CNT*CNT_BITS-1:0] pipe_q [STATS_DELAY];

            // Stats bus delay line, kept in step with done_q.
            always_ff @(posedge aclk) begin
                if (rst) begin
                    for (int k = 0; k < STATS_DELAY; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else begin
                    pipe_q[0] <= shadow_flat;
                    for (int k = 1; k < STATS_DELAY; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign stats_out = pipe_q[STATS_DELAY-1];
        end
    endgenerate

    // Read mux over the shadow; indices past the last counter read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < N_CNT; i++) begin
            if (rd_idx == 6'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge aclk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ovf     = ovf_q;

    // Stall counter counts consecutive valid-without-ready cycles, saturating at the threshold.
    always_comb begin
        stall_d = 16'd0;
        if (mon_valid && !mon_ready) begin
            stall_d = (stall_q == THRS) ? stall_q : stall_q + 16'd1;
        end
        stream_down_d = (stall_d == THRS);
    end

    // Stall counter and stream-down flag; the flag tracks the counter it is registered with.
    always_ff @(posedge aclk) begin
        if (rst) begin
            stall_q       <= 16'd0;
            stream_down_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            stream_down_q <= stream_down_d;
        end
    end

    assign stream_down = stream_down_q;

endmodule

// File: tb/tb_net_stats_agg.sv
module tb_net_stats_agg;

    logic        aclk = 1'b0;
    logic        rst;
    logic [15:0] evt_inc;
    logic        snap;
    logic        clr;
    logic [5:0]  rd_idx;
    logic        mon_valid;
    logic        mon_ready;

    // dut0: defaults
    logic [31:0]  d0_rd;
    logic [511:0] d0_stats;
    logic         d0_done;
    logic [15:0]  d0_ovf;
    logic         d0_down;
    // dut1: 4 x 8-bit saturating, no delay, threshold 4
    logic [7:0]   d1_rd;
    logic [31:0]  d1_stats;
    logic         d1_done;
    logic [3:0]   d1_ovf;
    logic         d1_down;
    // dut2: 4 x 8-bit wrapping, one delay stage
    logic [7:0]   d2_rd;
    logic [31:0]  d2_stats;
    logic         d2_done;
    logic [3:0]   d2_ovf;
    logic         d2_down;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    net_stats_agg u_dut0 (
        .aclk(aclk), .rst(rst), .evt_inc(evt_inc), .snap(snap), .clr(clr), .rd_idx(rd_idx),
        .rd_data(d0_rd), .stats_out(d0_stats), .snap_done(d0_done), .ovf(d0_ovf),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .stream_down(d0_down)
    );

    net_stats_agg #(.N_CNT(4), .CNT_BITS(8), .SATURATE(1), .STATS_DELAY(0), .DOWN_THRS(4)) u_dut1 (
        .aclk(aclk), .rst(rst), .evt_inc(evt_inc[3:0]), .snap(snap), .clr(clr), .rd_idx(rd_idx),
        .rd_data(d1_rd), .stats_out(d1_stats), .snap_done(d1_done), .ovf(d1_ovf),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .stream_down(d1_down)
    );

    net_stats_agg #(.N_CNT(4), .CNT_BITS(8), .SATURATE(0), .STATS_DELAY(1), .DOWN_THRS(4)) u_dut2 (
        .aclk(aclk), .rst(rst), .evt_inc(evt_inc[3:0]), .snap(snap), .clr(clr), .rd_idx(rd_idx),
        .rd_data(d2_rd), .stats_out(d2_stats), .snap_done(d2_done), .ovf(d2_ovf),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .stream_down(d2_down)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_live();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (d0_rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%0h exp=0", d0_rd); end
        total++; if (d0_stats !== 512'd0) begin bad++; $display("FAIL reset_stats got=%0h exp=0", d0_stats); end
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", d0_done); end
        total++; if (d0_ovf !== 16'd0) begin bad++; $display("FAIL reset_ovf got=%0h exp=0", d0_ovf); end
        total++; if (d0_down !== 1'b0) begin bad++; $display("FAIL reset_down got=%0b exp=0", d0_down); end
        total++; if (d1_stats !== 32'd0) begin bad++; $display("FAIL reset_d1_stats got=%0h exp=0", d1_stats); end
        rst = 1'b0;
    endtask

    // 10 pulses on counter 3, one snap, watch the delayed bus and done pulses.
    task automatic test_count_snap();
        clear_live();
        evt_inc = 16'h0008;
        repeat (10) tick();
        evt_inc = 16'h0000;
        snap    = 1'b1;
        rd_idx  = 6'd3;
        tick();
        snap = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            total++; if (d0_done !== (c == 5)) begin bad++; $display("FAIL snap_done_d0 c=%0d got=%0b exp=%0b", c, d0_done, (c == 5)); end
            total++; if (d1_done !== (c == 1)) begin bad++; $display("FAIL snap_done_d1 c=%0d got=%0b exp=%0b", c, d1_done, (c == 1)); end
            total++; if (d2_done !== (c == 2)) begin bad++; $display("FAIL snap_done_d2 c=%0d got=%0b exp=%0b", c, d2_done, (c == 2)); end
            if (c == 1) begin
                total++; if (d1_stats[31:24] !== 8'd10) begin bad++; $display("FAIL d1_stats3 got=%0d exp=10", d1_stats[31:24]); end
            end
            if (c == 2) begin
                total++; if (d0_rd !== 32'd10) begin bad++; $display("FAIL rd_cnt3 got=%0d exp=10", d0_rd); end
            end
            if (c == 4) begin
                total++; if (d0_stats[127:96] !== 32'd0) begin bad++; $display("FAIL stats3_early got=%0d exp=0", d0_stats[127:96]); end
            end
            if (c == 5) begin
                total++; if (d0_stats[127:96] !== 32'd10) begin bad++; $display("FAIL stats3 got=%0d exp=10", d0_stats[127:96]); end
            end
            tick();
        end
    endtask

    // Two consecutive snaps: two pulses in order, each carrying its own sample.
    task automatic test_back_to_back();
        evt_inc = 16'h0020;
        snap    = 1'b1;
        tick();
        evt_inc = 16'h0000;
        tick();
        snap = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            total++; if (d0_done !== (c == 5 || c == 6)) begin bad++; $display("FAIL b2b_done c=%0d got=%0b exp=%0b", c, d0_done, (c == 5 || c == 6)); end
            if (c == 5) begin
                total++; if (d0_stats[191:160] !== 32'd0) begin bad++; $display("FAIL b2b_first got=%0d exp=0", d0_stats[191:160]); end
            end
            if (c == 6) begin
                total++; if (d0_stats[191:160] !== 32'd1) begin bad++; $display("FAIL b2b_second got=%0d exp=1", d0_stats[191:160]); end
            end
            tick();
        end
    endtask

    // 300 pulses on counter 0: saturate vs wrap, sticky ovf, then clear.
    task automatic test_saturate();
        clear_live();
        evt_inc = 16'h0001;
        repeat (300) tick();
        evt_inc = 16'h0000;
        tick();
        total++; if (d1_ovf !== 4'b0001) begin bad++; $display("FAIL sat_ovf got=%0b exp=0001", d1_ovf); end
        total++; if (d2_ovf !== 4'b0001) begin bad++; $display("FAIL wrap_ovf got=%0b exp=0001", d2_ovf); end
        total++; if (d0_ovf !== 16'd0) begin bad++; $display("FAIL wide_ovf got=%0h exp=0", d0_ovf); end
        snap   = 1'b1;
        rd_idx = 6'd0;
        tick();
        snap = 1'b0;
        total++; if (d1_stats[7:0] !== 8'd255) begin bad++; $display("FAIL sat_stats got=%0d exp=255", d1_stats[7:0]); end
        tick();
        total++; if (d1_rd !== 8'd255) begin bad++; $display("FAIL sat_rd got=%0d exp=255", d1_rd); end
        total++; if (d2_rd !== 8'd44) begin bad++; $display("FAIL wrap_rd got=%0d exp=44", d2_rd); end
        total++; if (d0_rd !== 32'd300) begin bad++; $display("FAIL wide_rd got=%0d exp=300", d0_rd); end
        total++; if (d2_stats[7:0] !== 8'd44) begin bad++; $display("FAIL wrap_stats got=%0d exp=44", d2_stats[7:0]); end
        clear_live();
        total++; if (d1_ovf !== 4'b0000) begin bad++; $display("FAIL sat_ovf_clr got=%0b exp=0", d1_ovf); end
        total++; if (d2_ovf !== 4'b0000) begin bad++; $display("FAIL wrap_ovf_clr got=%0b exp=0", d2_ovf); end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        total++; if (d1_rd !== 8'd0) begin bad++; $display("FAIL sat_rd_clr got=%0d exp=0", d1_rd); end
        total++; if (d2_rd !== 8'd0) begin bad++; $display("FAIL wrap_rd_clr got=%0d exp=0", d2_rd); end
    endtask

    // Counter 2 at 7, then evt_inc + snap + clr together: shadow 7, live 0.
    task automatic test_read_clear();
        clear_live();
        evt_inc = 16'h0004;
        repeat (7) tick();
        snap = 1'b1;
        clr  = 1'b1;
        tick();
        evt_inc = 16'h0000;
        snap    = 1'b0;
        clr     = 1'b0;
        rd_idx  = 6'd2;
        tick();
        total++; if (d0_rd !== 32'd7) begin bad++; $display("FAIL rc_shadow_d0 got=%0d exp=7", d0_rd); end
        total++; if (d1_rd !== 8'd7) begin bad++; $display("FAIL rc_shadow_d1 got=%0d exp=7", d1_rd); end
        total++; if (d2_rd !== 8'd7) begin bad++; $display("FAIL rc_shadow_d2 got=%0d exp=7", d2_rd); end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        total++; if (d0_rd !== 32'd0) begin bad++; $display("FAIL rc_live_d0 got=%0d exp=0", d0_rd); end
        total++; if (d1_rd !== 8'd0) begin bad++; $display("FAIL rc_live_d1 got=%0d exp=0", d1_rd); end
    endtask

    // Stall monitor with threshold 4 on dut1/dut2, 256 on dut0.
    task automatic test_stream();
        mon_valid = 1'b1;
        mon_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (d1_down !== (k >= 4)) begin bad++; $display("FAIL down_rise k=%0d got=%0b exp=%0b", k, d1_down, (k >= 4)); end
        end
        mon_ready = 1'b1;
        tick();
        total++; if (d1_down !== 1'b0) begin bad++; $display("FAIL down_fall got=%0b exp=0", d1_down); end
        mon_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (d2_down !== (k == 4)) begin bad++; $display("FAIL down_three k=%0d got=%0b exp=%0b", k, d2_down, (k == 4)); end
        end
        total++; if (d0_down !== 1'b0) begin bad++; $display("FAIL down_wide got=%0b exp=0", d0_down); end
        mon_valid = 1'b0;
        tick();
        total++; if (d1_down !== 1'b0) begin bad++; $display("FAIL down_novalid got=%0b exp=0", d1_down); end
    endtask

    // Out-of-range read index must not alias onto a real counter.
    task automatic test_rd_range();
        clear_live();
        evt_inc = 16'h0011;
        repeat (5) tick();
        evt_inc = 16'h0000;
        snap    = 1'b1;
        tick();
        snap   = 1'b0;
        rd_idx = 6'd4;
        tick();
        total++; if (d0_rd !== 32'd5) begin bad++; $display("FAIL rd_idx4 got=%0d exp=5", d0_rd); end
        rd_idx = 6'd20;
        tick();
        total++; if (d0_rd !== 32'd0) begin bad++; $display("FAIL rd_idx20_d0 got=%0d exp=0", d0_rd); end
        total++; if (d1_rd !== 8'd0) begin bad++; $display("FAIL rd_idx20_d1 got=%0d exp=0", d1_rd); end
    endtask

    // Reset two cycles after snap cancels the pulse; first post-reset cycle counts.
    task automatic test_rst_mid_snap();
        clear_live();
        evt_inc = 16'h0002;
        repeat (3) tick();
        evt_inc = 16'h0000;
        rd_idx  = 6'd1;
        snap    = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (d0_rd !== 32'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", d0_rd); end
        evt_inc = 16'h0002;
        tick();
        evt_inc = 16'h0000;
        for (int c = 0; c < 8; c++) begin
            total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL rst_stale_done c=%0d got=%0b exp=0", c, d0_done); end
            total++; if (d0_stats !== 512'd0) begin bad++; $display("FAIL rst_stale_stats c=%0d got=%0h exp=0", c, d0_stats); end
            tick();
        end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        total++; if (d0_rd !== 32'd1) begin bad++; $display("FAIL rst_first_cycle got=%0d exp=1", d0_rd); end
    endtask

    initial begin
        rst       = 1'b1;
        evt_inc   = 16'h0000;
        snap      = 1'b0;
        clr       = 1'b0;
        rd_idx    = 6'd0;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        test_reset();
        test_count_snap();
        test_back_to_back();
        test_saturate();
        test_read_clear();
        test_stream();
        test_rd_range();
        test_rst_mid_snap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
